// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V pipeline front end.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) used for pipeline bubbles
//   *_LSB/_MSB    : instruction field bit positions used by decode
//   fetch_entry_t : one prefetch slot, the PC and the instruction fetched there
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam int OP_LSB     = 0;
  localparam int OP_MSB     = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_BIT = 30;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry prefetch buffer. A slot is reserved (and its PC written) when a
// request is accepted; the instruction word is filled in later when the
// response returns. Only filled slots count as occupied and can be popped.
// Popping in the same cycle as a fill with count_o == 0 passes the response
// straight through (the head slot is the one being filled).
//
// Ports
//   clk_i, reset_i  : clock, synchronous active-high reset
//   clear_i         : drop every slot (redirect)
//   reserve_i       : reserve the next slot, storing reserve_pc_i
//   fill_i          : write fill_instr_i into the oldest unfilled slot
//   pop_i           : retire the head slot
//   head_o          : head slot contents (pc always valid once reserved)
//   count_o         : number of filled, not yet popped slots
// -----------------------------------------------------------------------------
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clear_i,
  input  logic            reserve_i,
  input  logic [XLEN-1:0] reserve_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_instr_i,
  input  logic            pop_i,
  output fetch_entry_t    head_o,
  output logic [PW:0]     count_o
);

  fetch_entry_t mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0] res_ptr;
  logic [PW:0] fill_ptr;
  logic [PW:0] rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      res_ptr  <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
    end else begin
      if (reserve_i) res_ptr  <= res_ptr + 1'b1;
      if (fill_i)    fill_ptr <= fill_ptr + 1'b1;
      if (pop_i)     rd_ptr   <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which slots hold meaningful data.
  always_ff @(posedge clk_i) begin
    if (reserve_i) mem[res_ptr[PW-1:0]].pc    <= reserve_pc_i;
    if (fill_i)    mem[fill_ptr[PW-1:0]].instr <= fill_instr_i;
  end

  assign head_o  = mem[rd_ptr[PW-1:0]];
  assign count_o = fill_ptr - rd_ptr;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch front end: owns the fetch PC, issues in-order requests to
// instruction memory (valid/ready), buffers responses in fetch_fifo and drives
// the F/D register consumed by decode. Handles decode stall/flush and
// execute-stage redirects (redirect wins over stall and flush).
//
// Parameters : RESET_PC (first fetch PC), DEPTH (prefetch entries, pow2 >= 2)
// Ports
//   clk_i, reset_i                 : clock, synchronous active-high reset
//   stall_d_i, flush_d_i           : decode hold / decode bubble
//   pc_src_e_i, pc_target_e_i      : redirect request and target
//   imem_req_valid_o/ready_i/addr_o: fetch request channel
//   imem_rsp_valid_i/data_i        : in-order response, always accepted
//   instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o : F/D register
//   op_d_o, funct3_d_o, funct7_d_o : decode fields of instr_d_o
// Optional (macro FETCH_PERF_EN):
//   fetch_count_o  : cycles in which F/D loaded a valid instruction
//   bubble_count_o : cycles with !stall_d_i && !valid_d_o
// -----------------------------------------------------------------------------
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            stall_d_i,
  input  logic            flush_d_i,
  input  logic            pc_src_e_i,
  input  logic [XLEN-1:0] pc_target_e_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic [XLEN-1:0] instr_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] pc_plus4_d_o,
  output logic            valid_d_o,
  output logic [6:0]      op_d_o,
  output logic [2:0]      funct3_d_o,
  output logic            funct7_d_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_count_o,
  output logic [31:0]     bubble_count_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_f;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_count;
  logic [PW:0]     fifo_count;
  fetch_entry_t    head;

  logic            credit_ok;
  logic            req_hs;
  logic            rsp_keep;
  logic            fifo_empty;
  logic            bypass;
  logic            load_valid;
  fetch_entry_t    load_entry;

  // Credit covers both buffered responses and requests still in flight
  // (including ones whose responses will be dropped), so a returning
  // response always has a slot.
  assign credit_ok        = (int'(fifo_count) + int'(outstanding)) < DEPTH;
  assign imem_req_valid_o = !reset_i && !pc_src_e_i && credit_ok;
  assign imem_req_addr_o  = pc_f;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;

  // A response arriving with a redirect belongs to the old path and is
  // discarded along with the rest.
  assign rsp_keep   = imem_rsp_valid_i && (drop_count == '0) && !pc_src_e_i && !reset_i;
  assign fifo_empty = (fifo_count == '0);
  assign bypass     = rsp_keep && fifo_empty && !stall_d_i;
  assign load_valid = !reset_i && !pc_src_e_i && !flush_d_i && !stall_d_i &&
                      (!fifo_empty || bypass);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    load_entry.pc    = head.pc;
    load_entry.instr = head.instr;
    if (fifo_empty) load_entry.instr = imem_rsp_data_i;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (pc_src_e_i),
    .reserve_i    (req_hs),
    .reserve_pc_i (pc_f),
    .fill_i       (rsp_keep),
    .fill_instr_i (imem_rsp_data_i),
    .pop_i        (load_valid),
    .head_o       (head),
    .count_o      (fifo_count)
  );

  // Fetch PC
  always_ff @(posedge clk_i) begin
    if (reset_i)         pc_f <= RESET_PC;
    else if (pc_src_e_i) pc_f <= pc_target_e_i;
    else if (req_hs)     pc_f <= pc_f + 32'd4;
  end

  // Requests in flight and responses still owed to the discarded path
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      case ({req_hs, imem_rsp_valid_i})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      if (pc_src_e_i)
        drop_count <= outstanding - OW'(imem_rsp_valid_i);
      else if (imem_rsp_valid_i && (drop_count != '0))
        drop_count <= drop_count - OW'(1);
    end
  end

  // F/D register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instr_d_o    <= NOP_INSTR;
      pc_d_o       <= '0;
      pc_plus4_d_o <= 32'd4;
      valid_d_o    <= 1'b0;
    end else if (pc_src_e_i || flush_d_i) begin
      instr_d_o <= NOP_INSTR;
      valid_d_o <= 1'b0;
    end else if (stall_d_i) begin
      valid_d_o <= valid_d_o;
    end else if (load_valid) begin
      instr_d_o    <= load_entry.instr;
      pc_d_o       <= load_entry.pc;
      pc_plus4_d_o <= load_entry.pc + 32'd4;
      valid_d_o    <= 1'b1;
    end else begin
      instr_d_o <= NOP_INSTR;
      valid_d_o <= 1'b0;
    end
  end

  assign op_d_o     = instr_d_o[OP_MSB:OP_LSB];
  assign funct3_d_o = instr_d_o[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7_d_o = instr_d_o[FUNCT7_BIT];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_count_o  <= '0;
      bubble_count_o <= '0;
    end else begin
      if (load_valid)              fetch_count_o  <= fetch_count_o + 32'd1;
      if (!stall_d_i && !valid_d_o) bubble_count_o <= bubble_count_o + 32'd1;
    end
  end
`endif

endmodule
